// File: rtl/biquad_sequencer.sv
// rtl/biquad_sequencer.sv - Step sequencer for a direct-form-II biquad datapath
//
// Purpose: for each accepted start, walks the five multiply-accumulate steps
// (fk = Uk + a1*fk1 + a2*fk2, yk = b0*fk + b1*fk1 + b2*fk2), pulses the
// matching load enable and shifts the fk history. Also handles flush, the
// sticky overrun flag and the completed-sample counter.
// Build option: BIQUAD_MULT_PIPE_EN selects the registered-multiplier variant,
// where each step holds its selects for two cycles and loads on the second.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, flush, ovr_clr new-sample strobe, history clear, overrun clear
//   controlS/C/Z          coefficient / state / addend select codes
//   ld_acum1..ld_yk       datapath register load enables
//   shift, clr_hist       fk history shift, history clear
//   busy, done, overrun   status (done is a one-cycle pulse, overrun sticky)
//   sample_count          completed samples, wraps modulo 2^SAMPLE_CNT_W
module biquad_sequencer #(
  parameter int SAMPLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    flush,
  input  logic                    ovr_clr,
  output logic [2:0]              controlS,
  output logic [1:0]              controlC,
  output logic [2:0]              controlZ,
  output logic                    ld_acum1,
  output logic                    ld_fk,
  output logic                    ld_acum2,
  output logic                    ld_acum3,
  output logic                    ld_yk,
  output logic                    shift,
  output logic                    clr_hist,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic [SAMPLE_CNT_W-1:0] sample_count
);

  typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5, UPDATE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              controlS_q, controlS_d;
  logic [1:0]              controlC_q, controlC_d;
  logic [2:0]              controlZ_q, controlZ_d;
  logic [4:0]              ld_q, ld_d;  // {acum1, fk, acum2, acum3, yk}
  logic                    shift_q, shift_d;
  logic                    clr_hist_q, clr_hist_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;
  logic [SAMPLE_CNT_W-1:0] count_q, count_d;
  logic                    step_done;
  logic                    ld_phase;
`ifdef BIQUAD_MULT_PIPE_EN
  logic                    phase_q, phase_d;
`endif

  // Outputs are decoded from the next state and registered, so each output
  // flop holds exactly the Moore decode of the current state.
  always_comb begin
    state_d = state_q;
`ifdef BIQUAD_MULT_PIPE_EN
    // Phase 0 (Sx_A) presents the operands to the multiplier register,
    // phase 1 (Sx_B) loads the registered product into the target register.
    phase_d   = (state_q != IDLE) && (state_q != UPDATE) && !phase_q;
    step_done = phase_q;
    ld_phase  = phase_d;
`else
    step_done = 1'b1;
    ld_phase  = 1'b1;
`endif
    case (state_q)
      IDLE:    if (start && !flush) state_d = S1;
      S1:      if (step_done) state_d = S2;
      S2:      if (step_done) state_d = S3;
      S3:      if (step_done) state_d = S4;
      S4:      if (step_done) state_d = S5;
      S5:      if (step_done) state_d = UPDATE;
      default: state_d = IDLE;
    endcase

    controlS_d = '0;
    controlC_d = '0;
    controlZ_d = '0;
    ld_d       = '0;
    case (state_d)
      S1: begin controlS_d = 3'd1; controlC_d = 2'd1; controlZ_d = 3'd1; ld_d = 5'b10000; end
      S2: begin controlS_d = 3'd2; controlC_d = 2'd2; controlZ_d = 3'd3; ld_d = 5'b01000; end
      S3: begin controlS_d = 3'd3; controlC_d = 2'd3; controlZ_d = 3'd0; ld_d = 5'b00100; end
      S4: begin controlS_d = 3'd4; controlC_d = 2'd1; controlZ_d = 3'd4; ld_d = 5'b00010; end
      S5: begin controlS_d = 3'd5; controlC_d = 2'd2; controlZ_d = 3'd5; ld_d = 5'b00001; end
      default: ;
    endcase
    if (!ld_phase) ld_d = '0;

    shift_d    = (state_d == UPDATE);
    done_d     = (state_d == UPDATE);
    busy_d     = (state_d != IDLE);
    // flush only acts in IDLE and takes priority over a coincident start.
    clr_hist_d = (state_q == IDLE) && flush;
    // Set wins over clear.
    overrun_d  = ((state_q != IDLE) && start) || (overrun_q && !ovr_clr);
    count_d    = count_q;
    if (state_d == UPDATE) count_d = count_q + SAMPLE_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      controlS_q <= '0;
      controlC_q <= '0;
      controlZ_q <= '0;
      ld_q       <= '0;
      shift_q    <= 1'b0;
      clr_hist_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      count_q    <= '0;
`ifdef BIQUAD_MULT_PIPE_EN
      phase_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      controlS_q <= controlS_d;
      controlC_q <= controlC_d;
      controlZ_q <= controlZ_d;
      ld_q       <= ld_d;
      shift_q    <= shift_d;
      clr_hist_q <= clr_hist_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      count_q    <= count_d;
`ifdef BIQUAD_MULT_PIPE_EN
      phase_q    <= phase_d;
`endif
    end
  end

  assign controlS = controlS_q;
  assign controlC = controlC_q;
  assign controlZ = controlZ_q;
  assign {ld_acum1, ld_fk, ld_acum2, ld_acum3, ld_yk} = ld_q;
  assign shift        = shift_q;
  assign clr_hist     = clr_hist_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overrun      = overrun_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_biquad_sequencer.sv
// tb/tb_biquad_sequencer.sv - Self-checking bench for biquad_sequencer
module tb_biquad_sequencer;

  localparam int CW = 4;
`ifdef BIQUAD_MULT_PIPE_EN
  localparam int P = 2;
`else
  localparam int P = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [2:0]    controlS;
  logic [1:0]    controlC;
  logic [2:0]    controlZ;
  logic          ld_acum1, ld_fk, ld_acum2, ld_acum3, ld_yk;
  logic          shift, clr_hist, busy, done, overrun;
  logic [CW-1:0] sample_count;

  biquad_sequencer #(.SAMPLE_CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .ovr_clr(ovr_clr),
    .controlS(controlS), .controlC(controlC), .controlZ(controlZ),
    .ld_acum1(ld_acum1), .ld_fk(ld_fk), .ld_acum2(ld_acum2), .ld_acum3(ld_acum3), .ld_yk(ld_yk),
    .shift(shift), .clr_hist(clr_hist), .busy(busy), .done(done), .overrun(overrun),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  bit exp_ovr = 1'b0;
  int exp_cnt = 0;

  // Q12 coefficients, datapath registers driven by the DUT, and the reference history.
  int a1, a2, b0, b1, b2, uk_in;
  int dp_acum1, dp_fk, dp_acum2, dp_acum3, dp_yk, dp_fk1, dp_fk2;
  int ref_fk1 = 0, ref_fk2 = 0;

  function automatic int mq(input int c, input int x);
    longint pr;
    pr = longint'(c) * longint'(x);
    return int'(pr >>> 12);
  endfunction

  function automatic int coef_v(input logic [2:0] s);
    case (s)
      3'd1: return a1;
      3'd2: return a2;
      3'd3: return b0;
      3'd4: return b1;
      3'd5: return b2;
      default: return 0;
    endcase
  endfunction

  function automatic int state_v(input logic [1:0] c);
    case (c)
      2'd1: return dp_fk1;
      2'd2: return dp_fk2;
      2'd3: return dp_fk;
      default: return 0;
    endcase
  endfunction

  function automatic int add_v(input logic [2:0] z);
    case (z)
      3'd1: return uk_in;
      3'd2: return dp_yk;
      3'd3: return dp_acum1;
      3'd4: return dp_acum2;
      3'd5: return dp_acum3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    int res;
    res = mq(coef_v(controlS), state_v(controlC)) + add_v(controlZ);
    if (clr_hist) begin
      dp_fk <= 0; dp_fk1 <= 0; dp_fk2 <= 0; dp_yk <= 0;
    end else begin
      if (ld_acum1) dp_acum1 <= res;
      if (ld_fk)    dp_fk    <= res;
      if (ld_acum2) dp_acum2 <= res;
      if (ld_acum3) dp_acum3 <= res;
      if (ld_yk)    dp_yk    <= res;
      if (shift) begin dp_fk2 <= dp_fk1; dp_fk1 <= dp_fk; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [16:0] obs_ctl();
    return {controlS, controlC, controlZ, ld_acum1, ld_fk, ld_acum2, ld_acum3, ld_yk,
            shift, done, busy, clr_hist};
  endfunction

  // Expected outputs for step s (0 idle, 1..5 MAC steps, 6 update); ldp marks the load cycle.
  function automatic logic [16:0] exp_ctl(input int s, input bit ldp);
    logic [2:0] es; logic [1:0] ec; logic [2:0] ez; logic [4:0] ld; logic sh;
    es = 0; ec = 0; ez = 0; ld = 0; sh = 0;
    case (s)
      1: begin es = 3'd1; ec = 2'd1; ez = 3'd1; ld = 5'b10000; end
      2: begin es = 3'd2; ec = 2'd2; ez = 3'd3; ld = 5'b01000; end
      3: begin es = 3'd3; ec = 2'd3; ez = 3'd0; ld = 5'b00100; end
      4: begin es = 3'd4; ec = 2'd1; ez = 3'd4; ld = 5'b00010; end
      5: begin es = 3'd5; ec = 2'd2; ez = 3'd5; ld = 5'b00001; end
      6: sh = 1'b1;
      default: ;
    endcase
    if (!ldp) ld = 0;
    return {es, ec, ez, ld, sh, sh, (s != 0), 1'b0};
  endfunction

  task automatic clk_step(input bit busy_now);
    if (reset) begin exp_ovr = 1'b0; exp_cnt = 0; end
    else if (start && busy_now) exp_ovr = 1'b1;
    else if (ovr_clr) exp_ovr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input bit clr);
    chk("idle_ctl", 32'(obs_ctl()), 32'(exp_ctl(0, 1'b0)));
    chk("idle_overrun", 32'(overrun), 32'(exp_ovr));
    ovr_clr = clr;
    clk_step(1'b0);
    ovr_clr = 1'b0;
  endtask

  // One full sample; stray_cyc / flush_cyc give the busy cycle (1 = t+1) to poke, 0 = none.
  task automatic run_sample(input int uk, input int stray_cyc, input bit stray_clr, input int flush_cyc);
    int c; int r_fk; int r_y; int n[5];
    r_fk = uk + mq(a1, ref_fk1) + mq(a2, ref_fk2);
    r_y  = mq(b0, r_fk) + mq(b1, ref_fk1) + mq(b2, ref_fk2);
    ref_fk2 = ref_fk1;
    ref_fk1 = r_fk;
    foreach (n[i]) n[i] = 0;
    chk("idle_ctl", 32'(obs_ctl()), 32'(exp_ctl(0, 1'b0)));
    chk("sample_count", 32'(sample_count), 32'(exp_cnt % (1 << CW)));
    chk("idle_overrun", 32'(overrun), 32'(exp_ovr));
    uk_in = uk;
    start = 1'b1;
    clk_step(1'b0);
    start = 1'b0;
    c = 0;
    for (int s = 1; s <= 6; s++) begin
      for (int p = 0; p < ((s == 6) ? 1 : P); p++) begin
        c++;
        chk($sformatf("ctl_t%0d", c), 32'(obs_ctl()), 32'(exp_ctl(s, p == P - 1)));
        chk($sformatf("overrun_t%0d", c), 32'(overrun), 32'(exp_ovr));
        n[0] += int'(ld_acum1); n[1] += int'(ld_fk); n[2] += int'(ld_acum2);
        n[3] += int'(ld_acum3); n[4] += int'(ld_yk);
        if (s == 6) begin
          chk("yk", 32'(dp_yk), 32'(r_y));
          exp_cnt++;
        end
        start   = (c == stray_cyc);
        ovr_clr = (c == stray_cyc) && stray_clr;
        flush   = (c == flush_cyc);
        clk_step(1'b1);
      end
    end
    start = 1'b0; ovr_clr = 1'b0; flush = 1'b0;
    chk("ld_once", 32'({n[0] == 1, n[1] == 1, n[2] == 1, n[3] == 1, n[4] == 1}), 32'(5'b11111));
  endtask

  initial begin
    a1 = int'($urandom_range(3600)) - 1800;
    a2 = int'($urandom_range(3600)) - 1800;
    b0 = int'($urandom_range(8192)) - 4096;
    b1 = int'($urandom_range(8192)) - 4096;
    b2 = int'($urandom_range(8192)) - 4096;
    uk_in = 0;

    reset = 1'b1;
    repeat (3) clk_step(1'b0);
    reset = 1'b0;
    chk("reset_ctl", 32'(obs_ctl()), 32'(0));
    chk("reset_overrun", 32'(overrun), 32'(0));
    chk("reset_count", 32'(sample_count), 32'(0));
    idle_cycle(1'b0);

    run_sample(2048, 0, 1'b0, 0);

    // flush and start together: one clr_hist pulse, no sequence, no overrun
    flush = 1'b1; start = 1'b1;
    clk_step(1'b0);
    flush = 1'b0; start = 1'b0;
    chk("flush_start_ctl", 32'(obs_ctl()), 32'(17'h1));
    chk("flush_start_overrun", 32'(overrun), 32'(exp_ovr));
    clk_step(1'b0);
    chk("after_flush_ctl", 32'(obs_ctl()), 32'(0));
    ref_fk1 = 0; ref_fk2 = 0;

    // impulse response
    run_sample(4096, 0, 1'b0, 0);
    for (int i = 0; i < 8; i++) run_sample(0, 0, 1'b0, 0);

    // overrun behaviour
    run_sample(1000, 3, 1'b0, 0);
    run_sample(0, 0, 1'b0, 0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    run_sample(-500, 4, 1'b1, 0);
    run_sample(300, 5 * P + 1, 1'b1, 0);
    idle_cycle(1'b1);

    // flush while busy (first cycle of S3) is ignored
    run_sample(700, 0, 1'b0, 2 * P + 1);

    // reset in the first cycle of S4
    idle_cycle(1'b0);
    start = 1'b1;
    clk_step(1'b0);
    start = 1'b0;
    for (int c = 1; c <= 3 * P; c++) begin
      chk($sformatf("pre_reset_ctl_t%0d", c), 32'(obs_ctl()), 32'(exp_ctl((c - 1) / P + 1, ((c - 1) % P) == P - 1)));
      start = (c == 2);
      clk_step(1'b1);
      start = 1'b0;
    end
    chk("s4_ctl", 32'(obs_ctl()), 32'(exp_ctl(4, P == 1)));
    chk("s4_overrun", 32'(overrun), 32'(exp_ovr));
    reset = 1'b1;
    clk_step(1'b1);
    reset = 1'b0;
    chk("mid_reset_ctl", 32'(obs_ctl()), 32'(0));
    chk("mid_reset_overrun", 32'(overrun), 32'(0));
    chk("mid_reset_count", 32'(sample_count), 32'(0));
    idle_cycle(1'b0);

    // randomized samples; enough to wrap the 4-bit counter
    for (int k = 0; k < 20; k++) begin
      int gap; int stray; int fl;
      gap   = int'($urandom_range(3));
      stray = ($urandom_range(2) == 0) ? int'($urandom_range(5 * P + 1, 1)) : 0;
      fl    = ($urandom_range(3) == 0) ? int'($urandom_range(5 * P + 1, 1)) : 0;
      for (int g = 0; g < gap; g++) idle_cycle(1'($urandom_range(1)));
      run_sample(int'($urandom_range(8192)) - 4096, stray, 1'($urandom_range(1)), fl);
    end
    idle_cycle(1'b0);
    chk("final_count", 32'(sample_count), 32'(exp_cnt % (1 << CW)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/biquad_sequencer.md
Name: biquad_sequencer

Overview:
- Control unit for the second-order IIR (biquad) datapath; drives the coefficient, state and addend select codes consumed by the datapath operand multiplexer.
- Per input sample, issues the five multiply-accumulate steps, pulses the register load enables, shifts the fk history and signals completion.
- Datapath per step: result = coef(controlS) * state(controlC) + addend(controlZ), registered at the end of the cycle in which the matching load enable is high.

Parameters:
- SAMPLE_CNT_W, 16, width of the processed-sample counter output.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  new-sample strobe (Uk valid); accepted only in IDLE.
- flush  input  1  clear filter history; accepted only in IDLE.
- ovr_clr  input  1  clears the sticky overrun flag.
- controlS  output  3  coefficient select: 000 zero, 001 a1, 010 a2, 011 b0, 100 b1, 101 b2.
- controlC  output  2  state select: 00 zero, 01 fk1, 10 fk2, 11 fk.
- controlZ  output  3  addend select: 000 zero, 001 Uk, 010 yk, 011 acum1, 100 acum2, 101 acum3.
- ld_acum1, ld_fk, ld_acum2, ld_acum3, ld_yk  output  1 each  datapath register load enables.
- shift  output  1  fk2<=fk1, fk1<=fk.
- clr_hist  output  1  zero fk, fk1, fk2, yk.
- busy  output  1  high from S1 through UPDATE.
- done  output  1  one-cycle pulse, yk valid.
- overrun  output  1  sticky: start arrived while busy.
- sample_count  output  SAMPLE_CNT_W  completed samples, modulo 2^SAMPLE_CNT_W.

Behaviour:
- Reset (synchronous, active-high, wins over everything, including mid-sequence): state IDLE; all selects 0; all enables, shift, clr_hist, busy, done, overrun 0; sample_count 0. An interrupted sequence performs no shift and raises no done.
- Moore outputs decoded from the registered state, so they are stable for the whole cycle.
- States and outputs (S/C/Z, load):
  - IDLE: 000/00/000, no load.
  - S1: 001/01/001, ld_acum1 (a1*fk1 + Uk).
  - S2: 010/10/011, ld_fk (a2*fk2 + acum1).
  - S3: 011/11/000, ld_acum2 (b0*fk).
  - S4: 100/01/100, ld_acum3 (b1*fk1 + acum2).
  - S5: 101/10/101, ld_yk (b2*fk2 + acum3).
  - UPDATE: 000/00/000, shift=1, done=1; sample_count += 1 (wraps to 0).
- Transitions: IDLE -> S1 on start & !flush; S1->S2->S3->S4->S5->UPDATE->IDLE unconditionally.
- Latency: start high in cycle t, S1 in t+1, done in t+6; next start is accepted at t+7 at the earliest.
- flush in IDLE: clr_hist=1 for the next cycle, state stays IDLE. flush and start together: flush wins, start dropped, no overrun. flush while busy is ignored.
- start in any non-IDLE state (UPDATE included) is ignored and sets overrun.
- overrun clears on ovr_clr. If set and clear coincide, set wins.
- Exactly one load enable is high per cycle. No load enable is high in IDLE or UPDATE.

Optional Feature:
- Macro: BIQUAD_MULT_PIPE_EN.
- Defined: supports a registered multiplier. Each step Sx splits into Sx_A then Sx_B. Both hold the Sx select codes; the load enable is high only in Sx_B. Start to done is 11 cycles (S1_A at t+1, done at t+11). busy covers S1_A through UPDATE.
- Undefined: single-cycle steps as above, 6-cycle latency.

Test Plan:
- Reset then a single start pulse -> selects follow 001/01/001, 010/10/011, 011/11/000, 100/01/100, 101/10/101 on cycles t+1..t+5; done and shift at t+6; sample_count=1; busy high for t+1..t+6.
- Datapath golden model, impulse Uk=1.0 then zeros for 8 samples -> yk matches the fixed-point biquad model bit-exact; each load enable appears exactly once per sample.
- start at t+3 during a sequence -> ignored, overrun=1 and stays set; ovr_clr alone -> 0; ovr_clr together with a new busy start -> overrun stays 1.
- flush and start in the same IDLE cycle -> clr_hist pulses one cycle, no S1, overrun=0. flush during S3 -> no clr_hist.
- reset asserted in S4 -> next cycle IDLE, all outputs 0, no done, sample_count=0.
- SAMPLE_CNT_W=4, 17 samples -> sample_count wraps 15 to 0 then reads 1. With BIQUAD_MULT_PIPE_EN, done at t+11 and each select pair held for 2 cycles.
